wb_pipeline: RTL and testbench

WB_PIPELINE -- requirements
Module: wb_pipeline

---
 rtl/wb_pkg.sv | 6 +
 rtl/wb_pipeline_load_extract.sv | 23 ++
 rtl/wb_pipeline.sv | 78 +++++++
 tb/tb_wb_pipeline.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings and defaults for the write-back stage
package wb_pkg;
  typedef enum logic [1:0] {SRC_MEM, SRC_ALU, SRC_LINK, SRC_IMM} src_sel_e;
  typedef enum logic [1:0] {LD_BYTE, LD_HALF, LD_WORD, LD_WORD_ALT} load_size_e;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/wb_pipeline_load_extract.sv
// load_extract: picks the byte/half lane of a memory word and sign/zero-extends it (in: mem_data, load_size, load_unsigned, byte_offset; out: ext_data)
module load_extract
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [OFF_W-1:0]  byte_offset,
  output logic [DATA_W-1:0] ext_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = mem_data[{byte_offset, 3'b000} +: 8];
    h = mem_data[{byte_offset >> 1, 4'b0000} +: 16];
    ext_data = load_size == LD_BYTE ? (load_unsigned ? DATA_W'(b) : DATA_W'($signed(b))) :
               load_size == LD_HALF ? (load_unsigned ? DATA_W'(h) : DATA_W'($signed(h))) :
               mem_data;
  end
endmodule

// File: rtl/wb_pipeline.sv
// wb_pipeline: write-back stage, source select + load extract into one register with stall/flush and a retired counter
module wb_pipeline
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = CNT_W_DEF,
  localparam int OFF_W     = $clog2(DATA_W / 8)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm_data,
  input  logic [1:0]            src_sel,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic [OFF_W-1:0]      byte_offset,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  reg_write,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [CNT_W-1:0]      retired
);
  logic [DATA_W-1:0]     ext_data, sel_data;
  logic                  cap;
  logic                  valid_d, valid_q, we_d, we_q;
  logic [REG_ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0]     data_d, data_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;

  load_extract #(.DATA_W(DATA_W)) u_ext (
    .mem_data(mem_data),
    .load_size(load_size),
    .load_unsigned(load_unsigned),
    .byte_offset(byte_offset),
    .ext_data(ext_data)
  );

  always_comb begin
    sel_data = src_sel == SRC_MEM ? ext_data : src_sel == SRC_ALU ? alu_data :
               src_sel == SRC_LINK ? pc_plus4 : imm_data;
    cap      = !flush && !stall;
    valid_d  = flush ? 1'b0 : stall ? valid_q : in_valid;
    we_d     = flush ? 1'b0 : stall ? we_q : in_valid && reg_write && |dest_reg;
    addr_d   = flush ? '0 : stall ? addr_q : dest_reg;
    data_d   = flush ? '0 : stall ? data_q : sel_data;
    cnt_d    = cap && in_valid ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid = valid_q;
  assign wb_we    = we_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;
  assign retired  = cnt_q;
endmodule

// File: tb/tb_wb_pipeline.sv
// tb_wb_pipeline: randomized and directed checks of wb_pipeline against a behavioural model
module tb_wb_pipeline;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          in_valid, stall, flush;
  logic [DW-1:0] mem_data, alu_data, pc_plus4, imm_data;
  logic [1:0]    src_sel, load_size, byte_offset;
  logic          load_unsigned, reg_write;
  logic [AW-1:0] dest_reg;
  logic          wb_valid, wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic          m_valid, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_cnt;

  wb_pipeline #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .stall(stall), .flush(flush),
    .mem_data(mem_data), .alu_data(alu_data), .pc_plus4(pc_plus4), .imm_data(imm_data),
    .src_sel(src_sel), .load_size(load_size), .load_unsigned(load_unsigned),
    .byte_offset(byte_offset), .dest_reg(dest_reg), .reg_write(reg_write),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .retired(retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_data();
    logic [DW-1:0] v;
    int unsigned sh;
    if (src_sel == 2'd1) return alu_data;
    if (src_sel == 2'd2) return pc_plus4;
    if (src_sel == 2'd3) return imm_data;
    if (load_size == 2'd0) begin
      sh = 8 * int'(byte_offset);
      v = (mem_data >> sh) & 32'hFF;
      if (!load_unsigned && v[7]) v = v | 32'hFFFF_FF00;
    end else if (load_size == 2'd1) begin
      sh = 16 * (int'(byte_offset) / 2);
      v = (mem_data >> sh) & 32'hFFFF;
      if (!load_unsigned && v[15]) v = v | 32'hFFFF_0000;
    end else v = mem_data;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
    chk({tag, ".we"}, 64'(wb_we), 64'(m_we));
    chk({tag, ".addr"}, 64'(wb_addr), 64'(m_addr));
    chk({tag, ".data"}, 64'(wb_data), 64'(m_data));
    chk({tag, ".retired"}, 64'(retired), 64'(m_cnt));
  endtask

  task automatic cyc(input string tag);
    logic          nv, nw;
    logic [AW-1:0] na;
    logic [DW-1:0] nd;
    int            nc;
    nv = m_valid; nw = m_we; na = m_addr; nd = m_data; nc = m_cnt;
    if (flush) begin
      nv = 0; nw = 0; na = '0; nd = '0;
    end else if (!stall) begin
      nv = in_valid;
      nw = in_valid && reg_write && dest_reg != 0;
      na = dest_reg;
      nd = ref_data();
      if (in_valid) nc = (m_cnt + 1) % (1 << CW);
    end
    @(posedge clock);
    #1;
    m_valid = nv; m_we = nw; m_addr = na; m_data = nd; m_cnt = nc;
    check_all(tag);
  endtask

  task automatic set_in(input logic v, input logic [1:0] ss, input logic [1:0] ls,
                        input logic u, input logic [1:0] off, input logic [AW-1:0] d,
                        input logic rw);
    in_valid = v; src_sel = ss; load_size = ls; load_unsigned = u;
    byte_offset = off; dest_reg = d; reg_write = rw;
  endtask

  task automatic pulse_reset();
    #2 resetn = 0;
    #1 model_reset();
    check_all("rst_pulse");
    #1 resetn = 1;
  endtask

  initial begin
    resetn = 0; stall = 0; flush = 0;
    mem_data = '0; alu_data = '0; pc_plus4 = '0; imm_data = '0;
    set_in(1, 2'd1, 2'd2, 0, 2'd0, 5'd3, 1);
    alu_data = 32'hDEAD_BEEF;
    model_reset();
    #8;
    check_all("reset_state");
    #4 resetn = 1;
    cyc("first_capture");
    chk("first_capture.data_const", 64'(wb_data), 64'hDEAD_BEEF);

    mem_data = 32'h80F0_1234;
    set_in(1, 2'd0, 2'd0, 0, 2'd2, 5'd4, 1);
    cyc("byte_s_off2");
    chk("byte_s_off2.const", 64'(wb_data), 64'hFFFF_FFF0);
    set_in(1, 2'd0, 2'd1, 1, 2'd3, 5'd5, 1);
    cyc("half_u_off3");
    chk("half_u_off3.const", 64'(wb_data), 64'h0000_80F0);
    set_in(1, 2'd0, 2'd2, 0, 2'd1, 5'd6, 1);
    cyc("word_off1");
    chk("word_off1.const", 64'(wb_data), 64'h80F0_1234);

    pc_plus4 = 32'h0040_0008;
    set_in(1, 2'd2, 2'd0, 0, 2'd1, 5'd31, 1);
    cyc("link_r31");
    chk("link_r31.we", 64'(wb_we), 64'd1);
    chk("link_r31.addr", 64'(wb_addr), 64'd31);
    set_in(1, 2'd2, 2'd0, 0, 2'd1, 5'd0, 1);
    cyc("link_r0");
    chk("link_r0.we", 64'(wb_we), 64'd0);
    chk("link_r0.valid", 64'(wb_valid), 64'd1);

    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      imm_data = 32'h100 + 32'(i);
      set_in(1, 2'd3, 2'd0, 0, 2'd0, 5'(i + 1), 1);
      cyc("three_caps");
    end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      imm_data = $urandom;
      set_in(1, 2'd3, 2'd0, 0, 2'd0, 5'd9, 1);
      cyc("stall_hold");
      chk("stall_hold.data_const", 64'(wb_data), 64'h102);
      chk("stall_hold.retired_const", 64'(retired), 64'd3);
    end
    flush = 1;
    cyc("stall_flush");
    chk("stall_flush.valid_const", 64'(wb_valid), 64'd0);
    chk("stall_flush.retired_const", 64'(retired), 64'd3);
    stall = 0; flush = 0;

    pulse_reset();
    set_in(1, 2'd1, 2'd0, 0, 2'd0, 5'd7, 1);
    for (int i = 0; i < 15; i++) begin
      alu_data = $urandom;
      cyc("cnt_fill");
    end
    chk("cnt_15", 64'(retired), 64'd15);
    cyc("cnt_wrap");
    chk("cnt_wrap.const", 64'(retired), 64'd0);
    set_in(0, 2'd1, 2'd0, 0, 2'd0, 5'd7, 1);
    cyc("invalid_capture");

    set_in(1, 2'd1, 2'd0, 0, 2'd0, 5'd8, 1);
    cyc("pre_stall");
    stall = 1;
    cyc("mid_stall");
    pulse_reset();
    chk("async_rst.valid_const", 64'(wb_valid), 64'd0);
    stall = 0;
    cyc("post_rst_capture");

    for (int i = 0; i < 400; i++) begin
      mem_data      = $urandom;
      alu_data      = $urandom;
      pc_plus4      = $urandom;
      imm_data      = $urandom;
      in_valid      = 1'($urandom_range(0, 1));
      src_sel       = 2'($urandom_range(0, 3));
      load_size     = 2'($urandom_range(0, 3));
      load_unsigned = 1'($urandom_range(0, 1));
      byte_offset   = 2'($urandom_range(0, 3));
      dest_reg      = 5'($urandom_range(0, 31));
      reg_write     = 1'($urandom_range(0, 1));
      stall         = $urandom_range(0, 4) == 0;
      flush         = $urandom_range(0, 9) == 0;
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
